term_sequencer: RTL and testbench

TERM_SEQUENCER -- requirements
Module: term_sequencer

---
 rtl/term_sequencer_pkg.sv | 23 ++
 rtl/term_counter.sv | 39 +++
 rtl/term_sequencer.sv | 100 ++++++++++
 tb/tb_term_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/term_sequencer_pkg.sv
// Shared constants for the term sequencer: FSM encodings, default term
// count and the controller phase names the sequencer works alongside.
package term_sequencer_pkg;

  localparam int N_TERMS_DEF = 8;
  localparam int IW_DEF      = 4;

  // Sequencer states; the encodings are fixed so other blocks can decode them.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } seq_state_e;

  // Datapath controller phases that issue the ldTmp/selTmp/ldX strobes.
  typedef enum logic [1:0] {
    C_INIT = 2'd0,
    C_LD   = 2'd1,
    C_MUL  = 2'd2,
    C_ADD  = 2'd3
  } ctrl_phase_e;

endpackage

// File: rtl/term_counter.sv
// IW-bit term index counter: synchronous clear, enable, saturates at LIMIT.
// hit_o flags the increment that lands on LIMIT; tc_o flags count == LIMIT.
module term_counter #(
  parameter int IW    = 4,
  parameter int LIMIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [IW-1:0] cnt_o,
  output logic          tc_o,
  output logic          hit_o
);

  localparam logic [IW-1:0] LIM = IW'(LIMIT);

  logic [IW-1:0] cnt_q, cnt_d;

  // Next count: clear wins over enable; increments stop at LIMIT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != LIM))
      cnt_d = cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == LIM);
  assign hit_o = (cnt_d == LIM) && (cnt_q != LIM);

endmodule

// File: rtl/term_sequencer.sv
// Term sequencer: counts completed series terms (ldX pulses), reports done
// to the controller, and issues a one-cycle valid when the controller
// acknowledges completion with ldTmp. All outputs come straight from flops.
module term_sequencer
  import term_sequencer_pkg::*;
#(
  parameter int N_TERMS = N_TERMS_DEF,
  parameter int IW      = IW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          ldTmp,
  input  logic          selTmp,
  input  logic          ldX,
  output logic          done,
  output logic [IW-1:0] iter,
  output logic          busy,
  output logic          valid,
  output logic          err
);

  seq_state_e state_q, state_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;

  logic cnt_clr, cnt_en, cnt_tc, cnt_hit;

  // A start is only accepted from IDLE; terms only count while running.
  assign cnt_clr = (state_q == S_IDLE) && start;
  assign cnt_en  = (state_q == S_RUN) && ldX;

  term_counter #(
    .IW    (IW),
    .LIMIT (N_TERMS)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (iter),
    .tc_o  (cnt_tc),
    .hit_o (cnt_hit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state: RUN ends on the ldX that completes the last term; FIN waits
  // for the controller's ldTmp (which also masks a coincident start).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start)              state_d = S_RUN;
      S_RUN:  if (cnt_hit || cnt_tc)  state_d = S_FIN;
      S_FIN:  if (ldTmp)              state_d = S_IDLE;
      default:                        state_d = S_IDLE;
    endcase
  end

  // Output next values, decoded from the upcoming state so they register
  // in lockstep with it.
  always_comb begin
    done_d  = (state_d == S_FIN);
    busy_d  = (state_d == S_RUN) || (state_d == S_FIN);
    valid_d = (state_q == S_FIN) && ldTmp;
    err_d   = err_q;
    if (cnt_clr)
      err_d = 1'b0;
    // A stray ldX outside RUN, or ldX together with selTmp, is a violation.
    if (ldX && ((state_q != S_RUN) || selTmp))
      err_d = 1'b1;
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q  <= done_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign done  = done_q;
  assign busy  = busy_q;
  assign valid = valid_q;
  assign err   = err_q;

endmodule

// File: tb/tb_term_sequencer.sv
// Directed bench for term_sequencer (N_TERMS=8, IW=4). Inputs change 1ns
// after a rising edge; outputs are checked 1ns after the following edge.
module tb_term_sequencer;

  localparam int NT = 8;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst, start, ldTmp, selTmp, ldX;
  logic          done, busy, valid, err;
  logic [IW-1:0] iter;

  int checks   = 0;
  int failures = 0;

  term_sequencer #(.N_TERMS(NT), .IW(IW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .ldTmp  (ldTmp),
    .selTmp (selTmp),
    .ldX    (ldX),
    .done   (done),
    .iter   (iter),
    .busy   (busy),
    .valid  (valid),
    .err    (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; ldTmp = 1'b0; selTmp = 1'b0; ldX = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({iter, done, busy, valid, err} !== {4'd0, 4'b0000}) begin
      failures++;
      $display("FAIL reset_state: iter=%0d done=%b busy=%b valid=%b err=%b, want all 0",
               iter, done, busy, valid, err);
    end
    // Run to iter=3 with an error flagged, then reset for 2 cycles mid-RUN.
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      ldX = 1'b1; selTmp = (k == 2); tick(); ldX = 1'b0; selTmp = 1'b0;
    end
    checks++;
    if ({iter, busy, err} !== {4'd3, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL pre_reset_run: iter=%0d busy=%b err=%b, want 3 1 1", iter, busy, err);
    end
    rst = 1'b1; tick();
    checks++;
    if ({iter, busy, done, err, valid} !== {4'd0, 4'b0000}) begin
      failures++;
      $display("FAIL mid_run_reset: iter=%0d busy=%b done=%b err=%b valid=%b, want 0",
               iter, busy, done, err, valid);
    end
    tick(); rst = 1'b0;
    tick();
    checks++;
    if ({busy, valid} !== 2'b00) begin
      failures++;
      $display("FAIL post_reset_idle: busy=%b valid=%b, want 0 0", busy, valid);
    end
  endtask

  task automatic test_nominal();
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if ({iter, busy, done, err} !== {4'd0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL nom_start: iter=%0d busy=%b done=%b err=%b, want 0 1 0 0",
               iter, busy, done, err);
    end
    for (int k = 1; k <= NT; k++) begin
      ldX = 1'b1; tick(); ldX = 1'b0;
      checks++;
      if ({iter, done, busy} !== {4'(k), (k == NT), 1'b1}) begin
        failures++;
        $display("FAIL nom_ldx%0d: iter=%0d done=%b busy=%b, want %0d %b 1",
                 k, iter, done, busy, k, (k == NT));
      end
      // ldTmp during RUN must be ignored.
      if (k == 4) ldTmp = 1'b1;
      tick(); ldTmp = 1'b0;
      tick();
      checks++;
      if ({iter, done, valid, busy} !== {4'(k), (k == NT), 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL nom_gap%0d: iter=%0d done=%b valid=%b busy=%b, want %0d %b 0 1",
                 k, iter, done, valid, busy, k, (k == NT));
      end
    end
    ldTmp = 1'b1; tick(); ldTmp = 1'b0;
    checks++;
    if ({done, busy, valid, iter} !== {3'b001, 4'd8}) begin
      failures++;
      $display("FAIL nom_ack: done=%b busy=%b valid=%b iter=%0d, want 0 0 1 8",
               done, busy, valid, iter);
    end
    tick();
    checks++;
    if ({done, busy, valid, iter} !== {3'b000, 4'd8}) begin
      failures++;
      $display("FAIL nom_after: done=%b busy=%b valid=%b iter=%0d, want 0 0 0 8",
               done, busy, valid, iter);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 1; k <= NT; k++) begin
      ldX = 1'b1; tick();
    end
    // Ninth ldX lands in FIN: flags err.
    tick(); ldX = 1'b0;
    ldTmp = 1'b1; tick(); ldTmp = 1'b0;
    checks++;
    if ({valid, err, busy} !== 3'b110) begin
      failures++;
      $display("FAIL b2b_valid: valid=%b err=%b busy=%b, want 1 1 0", valid, err, busy);
    end
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if ({iter, busy, err, valid} !== {4'd0, 3'b100}) begin
      failures++;
      $display("FAIL b2b_restart: iter=%0d busy=%b err=%b valid=%b, want 0 1 0 0",
               iter, busy, err, valid);
    end
  endtask

  task automatic test_protocol_err();
    do_reset();
    ldX = 1'b1; tick(); ldX = 1'b0;
    checks++;
    if ({err, iter, busy} !== {1'b1, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL idle_ldx: err=%b iter=%0d busy=%b, want 1 0 0", err, iter, busy);
    end
    tick();
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky: err=%b, want 1", err);
    end
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if ({err, busy, iter} !== {2'b01, 4'd0}) begin
      failures++;
      $display("FAIL err_clear_start: err=%b busy=%b iter=%0d, want 0 1 0", err, busy, iter);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      ldX = 1'b1; tick();
      checks++;
      if ({iter, done, err} !== {4'(k > NT ? NT : k), (k >= NT), (k > NT)}) begin
        failures++;
        $display("FAIL overrun%0d: iter=%0d done=%b err=%b, want %0d %b %b",
                 k, iter, done, err, (k > NT ? NT : k), (k >= NT), (k > NT));
      end
    end
    ldX = 1'b0;
    ldTmp = 1'b1; tick(); ldTmp = 1'b0;
    checks++;
    if ({valid, done, iter} !== {2'b10, 4'd8}) begin
      failures++;
      $display("FAIL overrun_ack: valid=%b done=%b iter=%0d, want 1 0 8", valid, done, iter);
    end
  endtask

  task automatic test_ignored_start();
    int vcount;
    do_reset();
    vcount = 0;
    start = 1'b1; tick();
    for (int k = 1; k <= NT; k++) begin
      ldX = 1'b1; tick(); ldX = 1'b0;
      if (valid === 1'b1) vcount++;
      checks++;
      if ({iter, err, busy} !== {4'(k), 2'b01}) begin
        failures++;
        $display("FAIL ign_start%0d: iter=%0d err=%b busy=%b, want %0d 0 1",
                 k, iter, err, busy, k);
      end
      tick();
      if (valid === 1'b1) vcount++;
    end
    checks++;
    if ({done, busy, iter} !== {2'b11, 4'd8}) begin
      failures++;
      $display("FAIL ign_fin_hold: done=%b busy=%b iter=%0d, want 1 1 8", done, busy, iter);
    end
    // start and ldTmp together in FIN: return to IDLE, start not taken.
    ldTmp = 1'b1; tick(); ldTmp = 1'b0; start = 1'b0;
    if (valid === 1'b1) vcount++;
    checks++;
    if ({valid, busy, done, iter} !== {3'b100, 4'd8}) begin
      failures++;
      $display("FAIL ign_ack: valid=%b busy=%b done=%b iter=%0d, want 1 0 0 8",
               valid, busy, done, iter);
    end
    tick();
    if (valid === 1'b1) vcount++;
    tick();
    if (valid === 1'b1) vcount++;
    checks++;
    if ({busy, iter} !== {1'b0, 4'd8} || vcount != 1) begin
      failures++;
      $display("FAIL ign_single_valid: busy=%b iter=%0d valid_pulses=%0d, want 0 8 1",
               busy, iter, vcount);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ldTmp = 1'b0; selTmp = 1'b0; ldX = 1'b0;
    test_reset();
    test_nominal();
    test_back_to_back();
    test_protocol_err();
    test_overrun();
    test_ignored_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
